// File: rtl/mem_access_ctrl.sv
// MEM-stage data RAM initiator. Loads get lane extraction and extension; sub-word stores use read-modify-write.
// Build macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the RAM and respond with misalign_err.
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_half,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  lat_cnt;
    logic        op_write, op_half, op_byte, op_signed;
    logic [1:0]  op_lane;
    logic [15:0] op_wdata;
    logic        accept, word_store, misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, merge_val;

    assign accept     = req_valid && (state == IDLE);
    assign word_store = req_write && !req_byte && !req_half;

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    assign misaligned   = !req_byte && (req_half ? req_addr[0] : (req_addr[1:0] != 2'b00));
    assign misalign_err = (state == RESP) && mis_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= misaligned;
        end
    end
`else
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned) begin
                        state_nxt = RESP;
                    end else if (word_store) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                mem_re = 1'b1;
                if (lat_cnt == 3'd1) begin
                    state_nxt = op_write ? WR : RESP;
                end
            end
            WR: begin
                mem_we     = 1'b1;
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte access wins over half when both request bits are set.
    always_comb begin
        rd_byte   = mem_rdata[{op_lane, 3'b000} +: 8];
        rd_half   = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val  = mem_rdata;
        merge_val = mem_rdata;
        if (op_byte) begin
            load_val = {{24{op_signed & rd_byte[7]}}, rd_byte};
            merge_val[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
        end else if (op_half) begin
            load_val = {{16{op_signed & rd_half[15]}}, rd_half};
            if (op_lane[1]) begin
                merge_val[31:16] = op_wdata;
            end else begin
                merge_val[15:0] = op_wdata;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_cnt    <= 3'd0;
            op_write   <= 1'b0;
            op_half    <= 1'b0;
            op_byte    <= 1'b0;
            op_signed  <= 1'b0;
            op_lane    <= 2'b00;
            op_wdata   <= 16'h0000;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            resp_rdata <= 32'h0;
        end else if (accept) begin
            op_write  <= req_write;
            op_half   <= req_half;
            op_byte   <= req_byte;
            op_signed <= req_signed;
            op_lane   <= req_addr[1:0];
            op_wdata  <= req_wdata[15:0];
            lat_cnt   <= 3'(MEM_LAT);
            mem_addr  <= {req_addr[31:2], 2'b00};
            if (misaligned || word_store) begin
                resp_rdata <= 32'h0;
            end
            if (word_store && !misaligned) begin
                mem_wdata <= req_wdata;
            end
        end else if (state == RD) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
                if (op_write) begin
                    mem_wdata  <= merge_val;
                    resp_rdata <= 32'h0;
                end else begin
                    resp_rdata <= load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/misalign sequences and
// randomized ops compared against a byte-lane reference model of the data RAM.
module tb_mem_access_ctrl;
    localparam int MEM_LAT = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid, req_ready, req_write, req_half, req_byte, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, misalign_err, mem_re, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_half(req_half), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: data only valid in the MEM_LAT-th consecutive read cycle, junk otherwise.
    logic [31:0] ram [0:63];
    int re_cnt = 0;
    always @(posedge Clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
        re_cnt <= mem_re ? re_cnt + 1 : 0;
    end
    assign mem_rdata = (mem_re && re_cnt == MEM_LAT - 1) ? ram[mem_addr[7:2]] : 32'hA5A5_5A5A;

    logic [31:0] ref_mem [0:63];

    typedef struct {
        string       name;
        logic        w, h, b, s;
        logic [31:0] addr, wdata, rdata, wd;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic w, h, b, s, input logic [31:0] addr, wdata, input bit noise,
                          output int lat, output logic [31:0] rdata, output logic mis,
                          output int we_n, output int re_n, output logic [31:0] wd_at_we,
                          output logic addr_ok);
        @(negedge Clk);
        check("no_back_to_back_resp", {31'b0, resp_valid}, 32'd0);
        check("ready_in_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_half = h; req_byte = b; req_signed = s;
        req_addr = addr; req_wdata = wdata;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        lat = -1; rdata = 32'h0; mis = 1'b0; we_n = 0; re_n = 0; wd_at_we = 32'h0; addr_ok = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            if (mem_re) begin
                re_n++;
                if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
            end
            if (mem_we) begin
                we_n++;
                wd_at_we = mem_wdata;
                if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
            end
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; mis = misalign_err;
                req_valid = 1'b0;
                break;
            end
            if (noise) begin
                req_valid = 1'($urandom); req_write = 1'($urandom); req_half = 1'($urandom);
                req_byte = 1'($urandom); req_signed = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic w, h, b, s, input logic [31:0] addr, wdata,
                            input bit noise, input logic [31:0] e_rd, input int e_lat, input logic e_mis,
                            input int e_we, input int e_re, input logic [31:0] e_wd);
        int lat, we_n, re_n;
        logic [31:0] rdata, wd;
        logic mis, aok;
        run_op(w, h, b, s, addr, wdata, noise, lat, rdata, mis, we_n, re_n, wd, aok);
        check($sformatf("%s_latency", tag), lat, e_lat);
        check($sformatf("%s_rdata", tag), rdata, e_rd);
        check($sformatf("%s_misalign", tag), {31'b0, mis}, {31'b0, e_mis});
        check($sformatf("%s_we_count", tag), we_n, e_we);
        check($sformatf("%s_re_count", tag), re_n, e_re);
        check($sformatf("%s_mem_addr", tag), {31'b0, aok}, 32'd1);
        if (e_we != 0) check($sformatf("%s_wdata", tag), wd, e_wd);
    endtask

    // Reference: pick the lane by size and offset arithmetically, extend or merge, update the model RAM.
    task automatic ref_op(input logic w, h, b, s, input logic [31:0] addr, wdata,
                          output logic [31:0] e_rd, output int e_lat, output logic e_mis,
                          output int e_we, output int e_re, output logic [31:0] e_wd);
        int unsigned size, off, idx;
        logic [31:0] mask, word, field;
        size = b ? 1 : (h ? 2 : 4);
        off  = (addr % 4) - ((addr % 4) % size);
        idx  = (addr / 4) % 64;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        e_mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        e_mis = (addr % size) != 0;
`endif
        word  = ref_mem[idx];
        field = (word >> (8 * off)) & mask;
        e_rd = 32'h0; e_wd = 32'h0; e_we = 0; e_re = 0;
        if (e_mis) begin
            e_lat = 1;
        end else if (w && size == 4) begin
            e_lat = 1; e_we = 1; e_wd = wdata; ref_mem[idx] = wdata;
        end else begin
            e_lat = MEM_LAT + 1; e_re = MEM_LAT;
            if (w) begin
                e_we = 1;
                e_wd = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
                ref_mem[idx] = e_wd;
            end else begin
                e_rd = field;
                if (s && size < 4 && field[8 * size - 1]) e_rd = field | ~mask;
            end
        end
    endtask

    task automatic model_op(input string tag, input logic w, h, b, s, input logic [31:0] addr, wdata,
                            input bit noise);
        logic [31:0] e_rd, e_wd;
        int e_lat, e_we, e_re;
        logic e_mis;
        ref_op(w, h, b, s, addr, wdata, e_rd, e_lat, e_mis, e_we, e_re, e_wd);
        check_op(tag, w, h, b, s, addr, wdata, noise, e_rd, e_lat, e_mis, e_we, e_re, e_wd);
    endtask

    task automatic add_vec(input string name, input logic w, h, b, s, input logic [31:0] addr, wdata,
                           rdata, wd, input int lat);
        vec_t v;
        v.name = name; v.w = w; v.h = h; v.b = b; v.s = s;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.wd = wd; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0; req_byte = 1'b0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        //          name      w  h  b  s  addr   wdata        rdata         mem_wdata     lat
        add_vec("lb41s",  0, 0, 1, 1, 32'h41, 32'h0,        32'h0000_0033, 32'h0,        4);
        add_vec("lh42s",  0, 1, 0, 1, 32'h42, 32'h0,        32'h0000_1122, 32'h0,        4);
        add_vec("lb43",   0, 0, 1, 0, 32'h43, 32'h0,        32'h0000_0011, 32'h0,        4);
        add_vec("lb10s",  0, 0, 1, 1, 32'h10, 32'h0,        32'hFFFF_FFF0, 32'h0,        4);
        add_vec("lbu10",  0, 0, 1, 0, 32'h10, 32'h0,        32'h0000_00F0, 32'h0,        4);
        add_vec("lh10s",  0, 1, 0, 1, 32'h10, 32'h0,        32'hFFFF_80F0, 32'h0,        4);
        add_vec("sb42",   1, 0, 1, 0, 32'h42, 32'h0000_00AB, 32'h0,        32'h11AB_3344, 4);
        add_vec("sh40",   1, 1, 0, 0, 32'h40, 32'h0000_BEEF, 32'h0,        32'h11AB_BEEF, 4);
        add_vec("lw40",   0, 0, 0, 0, 32'h40, 32'h0,        32'h11AB_BEEF, 32'h0,        4);
        add_vec("lb42s",  0, 0, 1, 1, 32'h42, 32'h0,        32'hFFFF_FFAB, 32'h0,        4);
        add_vec("lhu42",  0, 1, 0, 0, 32'h42, 32'h0,        32'h0000_11AB, 32'h0,        4);
        add_vec("sw80",   1, 0, 0, 0, 32'h80, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 1);
        add_vec("lw80",   0, 0, 0, 0, 32'h80, 32'h0,        32'hDEAD_BEEF, 32'h0,        4);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_re", {31'b0, mem_re}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        Reset = 1'b0;

        // Fill RAM through the DUT with word stores; the directed words land at 0x10 and 0x40.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = (i == 4) ? 32'h0000_80F0 : (i == 16) ? 32'h1122_3344 : $urandom;
            model_op($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 4), d, 1'b0);
        end

        foreach (vecs[i]) begin
            logic [31:0] e_rd, e_wd;
            int e_lat, e_we, e_re;
            logic e_mis;
            ref_op(vecs[i].w, vecs[i].h, vecs[i].b, vecs[i].s, vecs[i].addr, vecs[i].wdata,
                   e_rd, e_lat, e_mis, e_we, e_re, e_wd);
            check_op(vecs[i].name, vecs[i].w, vecs[i].h, vecs[i].b, vecs[i].s, vecs[i].addr,
                     vecs[i].wdata, 1'b0, vecs[i].rdata, vecs[i].lat, 1'b0,
                     vecs[i].w ? 1 : 0, (vecs[i].w && !vecs[i].h && !vecs[i].b) ? 0 : MEM_LAT,
                     vecs[i].wd);
        end

        // Reset while a load is in RD: the op must vanish without a response.
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b0; req_half = 1'b0; req_byte = 1'b0;
        req_signed = 1'b0; req_addr = 32'h80;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        check("rd_before_reset_mem_re", {31'b0, mem_re}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_mem_re", {31'b0, mem_re}, 32'd0);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_mem_addr", mem_addr, 32'h0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("postrst_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        check_op("lw80_after_rst", 0, 0, 0, 0, 32'h80, 32'h0, 1'b0,
                 32'hDEAD_BEEF, MEM_LAT + 1, 1'b0, 0, MEM_LAT, 32'h0);

`ifdef MISALIGN_TRAP_EN
        check_op("lw42_trap", 0, 0, 0, 0, 32'h42, 32'h0, 1'b0, 32'h0, 1, 1'b1, 0, 0, 32'h0);
        check_op("sh41_trap", 1, 1, 0, 0, 32'h41, 32'h5555, 1'b0, 32'h0, 1, 1'b1, 0, 0, 32'h0);
        check_op("lw40_untouched", 0, 0, 0, 0, 32'h40, 32'h0, 1'b0,
                 32'h11AB_BEEF, MEM_LAT + 1, 1'b0, 0, MEM_LAT, 32'h0);
`else
        check_op("lw42_word40", 0, 0, 0, 0, 32'h42, 32'h0, 1'b0,
                 32'h11AB_BEEF, MEM_LAT + 1, 1'b0, 0, MEM_LAT, 32'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            model_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 32'($urandom_range(0, 255)), $urandom, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
